// File: rtl/lap_capture_controller.sv
// rtl/lap_capture_controller.sv - stopwatch start/stop and lap/reset button controller
// Moore FSM with short/long press discrimination and a frozen lap display register.
module lap_capture_controller #(
   parameter int LONG_PRESS_TICKS = 2000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        btn_start_stop,
   input  logic        btn_lap_reset,
   input  logic [15:0] time_data,
   output logic        count_en,
   output logic        count_clr,
   output logic [15:0] display_data,
   output logic        lap_active,
   output logic [1:0]  state
);

   localparam int CW = $clog2(LONG_PRESS_TICKS + 1);
   localparam logic [CW-1:0] LONG_C  = CW'(LONG_PRESS_TICKS);
   localparam logic [CW-1:0] LONG_M1 = CW'(LONG_PRESS_TICKS - 1);

   localparam logic [1:0] S_IDLE    = 2'b00;
   localparam logic [1:0] S_RUNNING = 2'b01;
   localparam logic [1:0] S_PAUSED  = 2'b10;
   localparam logic [1:0] S_LAP     = 2'b11;

   logic [1:0]    state_q, state_d;
   logic          ss_prev_q, lr_prev_q;
   logic          armed_q, armed_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0]   lap_q, lap_d;
   logic [15:0]   disp_q, disp_d;
   logic          clr_q, clr_d;

   logic ss_rise, lr_rise, lr_fall, counting, long_fire, short_press;

   assign ss_rise     = btn_start_stop & ~ss_prev_q;
   assign lr_rise     = btn_lap_reset & ~lr_prev_q;
   assign lr_fall     = ~btn_lap_reset & lr_prev_q;
   // The press cycle itself counts as the first held tick.
   assign counting    = btn_lap_reset & (armed_q | lr_rise);
   assign long_fire   = counting & (cnt_q == LONG_M1);
   assign short_press = lr_fall & armed_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         ss_prev_q <= 1'b1;
         lr_prev_q <= 1'b1;
         armed_q   <= 1'b0;
         cnt_q     <= '0;
         lap_q     <= 16'h0000;
         disp_q    <= 16'h0000;
         clr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ss_prev_q <= btn_start_stop;
         lr_prev_q <= btn_lap_reset;
         armed_q   <= armed_d;
         cnt_q     <= cnt_d;
         lap_q     <= lap_d;
         disp_q    <= disp_d;
         clr_q     <= clr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      clr_d   = 1'b0;
      lap_d   = lap_q;
      if (long_fire) begin
         state_d = S_IDLE;
         clr_d   = 1'b1;
      end else if (ss_rise) begin
         case (state_q)
            S_IDLE:    state_d = S_RUNNING;
            S_RUNNING: state_d = S_PAUSED;
            S_PAUSED:  state_d = S_RUNNING;
            default:   state_d = S_PAUSED;
         endcase
      end else if (short_press) begin
         case (state_q)
            S_RUNNING: begin
               state_d = S_LAP;
               lap_d   = time_data;
            end
            S_LAP:     state_d = S_RUNNING;
            S_PAUSED: begin
               state_d = S_IDLE;
               clr_d   = 1'b1;
            end
            default:   clr_d = 1'b1;
         endcase
      end

      armed_d = armed_q;
      if (long_fire || !btn_lap_reset) begin
         armed_d = 1'b0;
      end else if (lr_rise) begin
         armed_d = 1'b1;
      end

      cnt_d = cnt_q;
      if (!btn_lap_reset) begin
         cnt_d = '0;
      end else if (counting && (cnt_q != LONG_C)) begin
         cnt_d = cnt_q + 1'b1;
      end

      disp_d = (state_d == S_LAP) ? lap_d : time_data;
   end

   always_comb begin
      state      = state_q;
      count_en   = (state_q == S_RUNNING) || (state_q == S_LAP);
      lap_active = (state_q == S_LAP);
   end

   assign display_data = disp_q;
   assign count_clr    = clr_q;

endmodule

// File: tb/tb_lap_capture_controller.sv
// tb/tb_lap_capture_controller.sv - self-checking bench for lap_capture_controller
module tb_lap_capture_controller;

   localparam int LONG = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        ss = 1'b0;
   logic        lr = 1'b0;
   logic [15:0] td = 16'h0000;
   logic        count_en, count_clr, lap_active;
   logic [15:0] display_data;
   logic [1:0]  state;

   int n_checks = 0;
   int n_err    = 0;
   bit chk_en   = 1'b0;

   lap_capture_controller #(.LONG_PRESS_TICKS(LONG)) dut (
      .clk           (clk),
      .reset         (reset),
      .btn_start_stop(ss),
      .btn_lap_reset (lr),
      .time_data     (td),
      .count_en      (count_en),
      .count_clr     (count_clr),
      .display_data  (display_data),
      .lap_active    (lap_active),
      .state         (state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: press length tracked as a plain hold count per press.
   int          m_state;
   logic [15:0] m_lap, m_disp;
   bit          m_clr, m_pss, m_plr, m_valid;
   int          m_hold;

   always @(posedge clk or negedge reset) begin : model
      bit rise_ss, long_p, short_p;
      int ns;
      if (!reset) begin
         m_state = 0; m_lap = 16'h0; m_disp = 16'h0; m_clr = 1'b0;
         m_pss = 1'b1; m_plr = 1'b1; m_valid = 1'b0; m_hold = 0;
      end else begin
         rise_ss = ss && !m_pss;
         if (lr) begin
            if (!m_plr) begin
               m_valid = 1'b1;
               m_hold  = 1;
            end else if (m_valid) begin
               m_hold++;
            end
         end
         long_p  = lr && m_valid && (m_hold == LONG);
         short_p = !lr && m_plr && m_valid;
         if (long_p || !lr) m_valid = 1'b0;
         ns    = m_state;
         m_clr = 1'b0;
         if (long_p) begin
            ns = 0; m_clr = 1'b1;
         end else if (rise_ss) begin
            ns = (m_state == 1 || m_state == 3) ? 2 : 1;
         end else if (short_p) begin
            case (m_state)
               1: begin ns = 3; m_lap = td; end
               3: ns = 1;
               2: begin ns = 0; m_clr = 1'b1; end
               default: m_clr = 1'b1;
            endcase
         end
         m_state = ns;
         m_disp  = (ns == 3) ? m_lap : td;
         m_pss   = ss;
         m_plr   = lr;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_state", 32'(state), 32'(m_state));
         check("model_count_en", 32'(count_en), 32'((m_state == 1) || (m_state == 3)));
         check("model_lap_active", 32'(lap_active), 32'(m_state == 3));
         check("model_count_clr", 32'(count_clr), 32'(m_clr));
         check("model_display", 32'(display_data), 32'(m_disp));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic ss_pulse();
      ss = 1'b1; cyc();
      ss = 1'b0; cyc();
   endtask

   task automatic short_press(input int n);
      lr = 1'b1;
      repeat (n) cyc();
      lr = 1'b0;
      cyc();
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_state"}, 32'(state), 32'd0);
      check({tag, "_count_en"}, 32'(count_en), 32'd0);
      check({tag, "_count_clr"}, 32'(count_clr), 32'd0);
      check({tag, "_display"}, 32'(display_data), 32'd0);
      check({tag, "_lap_active"}, 32'(lap_active), 32'd0);
   endtask

   initial begin
      repeat (3) cyc();
      check_zero("reset");
      chk_en = 1'b1;
      reset = 1'b1;
      cyc(); cyc();

      // Start/stop toggles RUNNING and PAUSED.
      ss = 1'b1; cyc();
      check("start_state", 32'(state), 32'd1);
      check("start_count_en", 32'(count_en), 32'd1);
      ss = 1'b0; cyc();
      ss = 1'b1; cyc();
      check("stop_state", 32'(state), 32'd2);
      check("stop_count_en", 32'(count_en), 32'd0);
      ss = 1'b0; cyc();

      // Lap capture freezes display while time advances.
      ss_pulse();
      td = 16'h0123;
      short_press(3);
      check("lap_state", 32'(state), 32'd3);
      check("lap_display", 32'(display_data), 32'h0123);
      td = 16'h0150;
      repeat (3) cyc();
      check("lap_frozen", 32'(display_data), 32'h0123);
      short_press(2);
      check("unlap_state", 32'(state), 32'd1);
      check("unlap_display", 32'(display_data), 32'h0150);
      td = 16'h0151;
      cyc();
      check("track_display", 32'(display_data), 32'h0151);

      // Short press while paused clears.
      ss_pulse();
      check("paused", 32'(state), 32'd2);
      short_press(1);
      check("pclr_pulse", 32'(count_clr), 32'd1);
      check("pclr_state", 32'(state), 32'd0);
      cyc();
      check("pclr_single", 32'(count_clr), 32'd0);

      // Long press boundary: 8 held cycles fire, 7 are a short press.
      ss_pulse();
      lr = 1'b1;
      repeat (7) cyc();
      check("long7_state", 32'(state), 32'd1);
      check("long7_clr", 32'(count_clr), 32'd0);
      cyc();
      check("long8_clr", 32'(count_clr), 32'd1);
      check("long8_state", 32'(state), 32'd0);
      cyc();
      check("long_single", 32'(count_clr), 32'd0);
      repeat (4) cyc();
      lr = 1'b0;
      repeat (2) cyc();
      check("long_release_state", 32'(state), 32'd0);
      check("long_release_clr", 32'(count_clr), 32'd0);
      ss_pulse();
      short_press(7);
      check("short7_state", 32'(state), 32'd3);
      lr = 1'b1;
      repeat (8) cyc();
      check("long_from_lap_state", 32'(state), 32'd0);
      check("long_from_lap_clr", 32'(count_clr), 32'd1);
      lr = 1'b0; cyc();

      // Start/stop rise beats a same-cycle short press.
      ss_pulse();
      td = 16'h0777;
      lr = 1'b1;
      repeat (2) cyc();
      lr = 1'b0; ss = 1'b1;
      cyc();
      check("prio_state", 32'(state), 32'd2);
      check("prio_lap_active", 32'(lap_active), 32'd0);
      check("prio_display", 32'(display_data), 32'h0777);
      ss = 1'b0; cyc();
      ss_pulse();
      td = 16'h0900;
      short_press(1);
      check("relap_display", 32'(display_data), 32'h0900);

      // Long press beats a same-cycle start/stop rise.
      lr = 1'b1;
      repeat (7) cyc();
      ss = 1'b1;
      cyc();
      check("prio_long_state", 32'(state), 32'd0);
      check("prio_long_clr", 32'(count_clr), 32'd1);
      ss = 1'b0; lr = 1'b0; cyc();

      // Button held through reset release gives no edge.
      reset = 1'b0; ss = 1'b1;
      repeat (2) cyc();
      reset = 1'b1;
      repeat (3) cyc();
      check("held_reset_state", 32'(state), 32'd0);
      ss = 1'b0; cyc();
      check("held_release_state", 32'(state), 32'd0);
      ss = 1'b1; cyc();
      check("held_repress_state", 32'(state), 32'd1);
      ss = 1'b0; cyc();

      // Reset in LAP mid long press aborts immediately, no clear.
      td = 16'h0042;
      short_press(2);
      check("pre_reset_lap", 32'(state), 32'd3);
      lr = 1'b1;
      repeat (4) cyc();
      reset = 1'b0;
      #1;
      check_zero("async_reset");
      repeat (2) cyc();
      reset = 1'b1;
      repeat (10) cyc();
      check("post_reset_state", 32'(state), 32'd0);
      check("post_reset_clr", 32'(count_clr), 32'd0);
      lr = 1'b0; cyc();
      check("post_release_clr", 32'(count_clr), 32'd0);
      cyc();

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/lap_capture_controller.md
LAP_CAPTURE_CONTROLLER -- requirements
Module: lap_capture_controller

Interface
REQ-001 SHALL have parameter LONG_PRESS_TICKS, default 2000, meaning lap/reset hold cycles for a long-press clear (1 s at 2 kHz).
REQ-002 SHALL have port clk, input, 1, single clock (2 kHz divided clock); all state on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset).
REQ-004 SHALL have port btn_start_stop, input, 1, debounced start/stop level, active-high.
REQ-005 SHALL have port btn_lap_reset, input, 1, debounced lap/reset level, active-high.
REQ-006 SHALL have port time_data, input, 16, live 4-digit BCD time from the counter stage.
REQ-007 SHALL have port count_en, output, 1, counter-stage run enable.
REQ-008 SHALL have port count_clr, output, 1, single-cycle counter clear pulse.
REQ-009 SHALL have port display_data, output, 16, BCD value for the seven-segment stage.
REQ-010 SHALL have port lap_active, output, 1, high while the display is frozen on a lap.
REQ-011 SHALL have port state, output, 2, FSM state code.

Function
REQ-012 SHALL implement a Moore FSM with states IDLE=00, RUNNING=01, PAUSED=10, LAP=11; state output equals the state register.
REQ-013 SHALL register the previous level of each button and detect rising edges as level=1 with prev=0.
REQ-014 SHALL set an armed flag on a btn_lap_reset rising edge; a short press is a falling edge while armed with press counter < LONG_PRESS_TICKS.
REQ-015 SHALL count cycles while btn_lap_reset=1 and armed, saturating at LONG_PRESS_TICKS, counter width clog2(LONG_PRESS_TICKS+1); clear to 0 on release.
REQ-016 SHALL fire a long press in the single cycle the counter reaches LONG_PRESS_TICKS: next state IDLE from any state, count_clr=1 for one cycle, armed cleared, and the subsequent release does nothing.
REQ-017 SHALL handle a start/stop rise as: IDLE->RUNNING, RUNNING->PAUSED, PAUSED->RUNNING, LAP->PAUSED (hold released).
REQ-018 SHALL handle a short press as: RUNNING->LAP with lap register <= time_data in that cycle; LAP->RUNNING; PAUSED->IDLE with count_clr pulse; IDLE->IDLE with count_clr pulse.
REQ-019 SHALL apply same-cycle event priority long press > start/stop rise > short press; the lower-priority event is discarded, not deferred.
REQ-020 SHALL drive count_en=1 exactly when the state register is RUNNING or LAP.
REQ-021 SHALL drive lap_active=1 exactly when the state register is LAP.
REQ-022 SHALL register display_data every cycle as lap register when the next state is LAP, else time_data, giving 1-cycle latency.
REQ-023 SHALL register count_clr and assert it for exactly one cycle per clear event, never two consecutive cycles from one press.
REQ-024 SHALL not modify time_data digits: no arithmetic; BCD passes through bit-exact.

Reset
REQ-025 SHALL, while reset=0, asynchronously force state=IDLE, count_en=0, count_clr=0, display_data=16'h0000, lap_active=0, lap register=0, press counter=0, armed=0.
REQ-026 SHALL reset both button prev registers to 1, so a button held through reset release produces no edge until it is released and pressed again.
REQ-027 SHALL make assertion of reset mid-operation (any state, mid long-press) abort all activity with no count_clr pulse emitted.

Verification
REQ-028 SHALL pass: reset release, start/stop pulse -> state 01, count_en=1 next cycle; second pulse -> state 10, count_en=0.
REQ-029 SHALL pass: RUNNING, time_data=16'h0123, lap short press -> state 11, display_data holds 16'h0123 while time_data advances to 16'h0150; second short press -> display tracks time_data after 1 cycle.
REQ-030 SHALL pass: PAUSED, lap short press -> count_clr high exactly 1 cycle, state 00.
REQ-031 SHALL pass: with LONG_PRESS_TICKS=8, in RUNNING, lap held 8 cycles -> count_clr single pulse, state 00; release -> no further change; held 7 cycles -> treated as short press (state 11).
REQ-032 SHALL pass: start/stop rise and lap short-press release in the same cycle from RUNNING -> state 10 only, no lap capture.
REQ-033 SHALL pass: btn_start_stop held high across reset release -> state stays 00 until release and re-press; reset asserted in LAP -> all outputs zero immediately.
